pe_stream_feeder: RTL and testbench

Operand sequencer that drives a processing-element chain and collects its result. Holds a DEPTH-entry buffer of (x, w) pairs loaded over a ready/valid port. On a start command it streams the pairs into the PE inputs one per cycle, with the initial partial sum on the first pair. It then waits out the PE pipeline latency, captures the final PE partial sum, and reports it with a one-cycle valid pulse.

---
 rtl/pe_feeder_pkg.sv | 19 +
 rtl/pe_feeder_buf.sv | 29 ++
 rtl/pe_stream_feeder.sv | 144 ++++++++++++++
 tb/tb_pe_stream_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// Shared types and sizing helpers for the PE stream feeder.
// The optional replay behaviour is selected with the PE_FEEDER_REPLAY_EN macro.
package pe_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int DEPTH_DFLT = 4;
  localparam int LAT_DFLT   = 3;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_feeder_buf.sv
// Operand buffer: DEPTH entries of {x, w}, one write port, one asynchronous read port.
// Contents are not reset; only the fill count in the parent decides what is valid.
module pe_feeder_buf
  import pe_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DFLT,
  parameter int XW    = 8,
  parameter int WW    = 8,
  localparam int AW   = cnt_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [XW-1:0] wr_x,
  input  logic [WW-1:0] wr_w,
  input  logic [AW-1:0] rd_addr,
  output logic [XW-1:0] rd_x,
  output logic [WW-1:0] rd_w
);

  logic [XW+WW-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= {wr_x, wr_w};
  end

  assign {rd_x, rd_w} = mem[rd_addr];

endmodule

// File: rtl/pe_stream_feeder.sv
// Streams a buffered (x, w) vector into a PE chain and captures the chain's final sum.
// With PE_FEEDER_REPLAY_EN defined the buffer stays full after a run so it can be replayed.
module pe_stream_feeder
  import pe_feeder_pkg::*;
#(
  parameter int XW    = 8,
  parameter int WW    = 8,
  parameter int BW1   = 16,
  parameter int BW2   = 17,
  parameter int DEPTH = DEPTH_DFLT,
  parameter int LAT   = LAT_DFLT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_ld_valid,
  output logic           o_ld_ready,
  input  logic [XW-1:0]  i_ld_x,
  input  logic [WW-1:0]  i_ld_w,
  input  logic           i_start,
  input  logic [BW1-1:0] i_psum_init,
  output logic [XW-1:0]  o_x,
  output logic [WW-1:0]  o_w,
  output logic [BW1-1:0] o_psum,
  output logic           o_valid,
  input  logic [BW2-1:0] i_pe_psum,
  output logic [BW2-1:0] o_result,
  output logic           o_result_valid,
  output logic           o_busy
);

  localparam int IW = cnt_w(DEPTH);
  localparam int CW = cnt_w(DEPTH + 1);
  localparam int DW = cnt_w(LAT);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [DW-1:0] DRN_LAST = DW'(LAT - 2);

  state_t        state;
  logic [CW-1:0] wr_cnt;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] drn_cnt;
  logic [IW-1:0] rd_addr;
  logic [XW-1:0] rd_x;
  logic [WW-1:0] rd_w;
  logic          ld_fire;
  logic          done;

  // Load port: a pair transfers on a rising edge where i_ld_valid and o_ld_ready
  // are both high; i_ld_x/i_ld_w must be stable while i_ld_valid is high.
  assign o_ld_ready = (state == ST_IDLE) && (wr_cnt < FULL);
  assign ld_fire    = i_ld_valid && o_ld_ready;

  pe_feeder_buf #(
    .DEPTH (DEPTH),
    .XW    (XW),
    .WW    (WW)
  ) u_buf (
    .i_clk   (i_clk),
    .wr_en   (ld_fire),
    .wr_addr (wr_cnt[IW-1:0]),
    .wr_x    (i_ld_x),
    .wr_w    (i_ld_w),
    .rd_addr (rd_addr),
    .rd_x    (rd_x),
    .rd_w    (rd_w)
  );

  // rd_idx is the pair currently on the outputs, so the read port looks one ahead.
  always_comb begin
    rd_addr = '0;
    if (state == ST_STREAM && rd_idx != LAST_IDX) rd_addr = rd_idx + 1'b1;
  end

  always_comb begin
    done = 1'b0;
    if (state == ST_STREAM && rd_idx == LAST_IDX && LAT == 1) done = 1'b1;
    if (state == ST_DRAIN && drn_cnt == DRN_LAST) done = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      wr_cnt         <= '0;
      rd_idx         <= '0;
      drn_cnt        <= '0;
      o_x            <= '0;
      o_w            <= '0;
      o_psum         <= '0;
      o_valid        <= 1'b0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ld_fire) wr_cnt <= wr_cnt + 1'b1;
          if (i_start && wr_cnt == FULL) begin
            state   <= ST_STREAM;
            rd_idx  <= '0;
            o_x     <= rd_x;
            o_w     <= rd_w;
            o_psum  <= i_psum_init;
            o_valid <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (rd_idx != LAST_IDX) begin
            rd_idx <= rd_idx + 1'b1;
            o_x    <= rd_x;
            o_w    <= rd_w;
            o_psum <= '0;
          end else begin
            o_x     <= '0;
            o_w     <= '0;
            o_psum  <= '0;
            o_valid <= 1'b0;
            drn_cnt <= '0;
            if (LAT > 1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          drn_cnt <= drn_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase

      // The last operand has cleared the PE pipeline: its sum is on i_pe_psum now.
      if (done) begin
        state          <= ST_IDLE;
        o_result       <= i_pe_psum;
        o_result_valid <= 1'b1;
        o_busy         <= 1'b0;
`ifdef PE_FEEDER_REPLAY_EN
        wr_cnt         <= wr_cnt;
`else
        wr_cnt         <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Self-checking bench for pe_stream_feeder: a LAT=3 and a LAT=1 instance share stimulus,
// each fed by a behavioural PE whose sum is psum + x*w, LAT cycles after launch.
module tb_pe_stream_feeder;

  localparam int XW    = 8;
  localparam int WW    = 8;
  localparam int BW1   = 16;
  localparam int BW2   = 17;
  localparam int DEPTH = 4;
`ifdef PE_FEEDER_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  // ---------------- clock / reset / shared inputs
  logic           i_clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_ld_valid = 1'b0;
  logic [XW-1:0]  i_ld_x = '0;
  logic [WW-1:0]  i_ld_w = '0;
  logic           i_start = 1'b0;
  logic [BW1-1:0] i_psum_init = '0;

  always #5 i_clk = ~i_clk;

  // ---------------- DUT outputs (3 = LAT 3, 1 = LAT 1)
  logic           o_ld_ready3, o_valid3, o_result_valid3, o_busy3;
  logic [XW-1:0]  o_x3;
  logic [WW-1:0]  o_w3;
  logic [BW1-1:0] o_psum3;
  logic [BW2-1:0] o_result3, i_pe_psum3;
  logic           o_ld_ready1, o_valid1, o_result_valid1, o_busy1;
  logic [XW-1:0]  o_x1;
  logic [WW-1:0]  o_w1;
  logic [BW1-1:0] o_psum1;
  logic [BW2-1:0] o_result1, i_pe_psum1;

  pe_stream_feeder #(.XW(XW), .WW(WW), .BW1(BW1), .BW2(BW2), .DEPTH(DEPTH), .LAT(3)) dut3 (
    .i_clk(i_clk), .i_rst(i_rst), .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready3),
    .i_ld_x(i_ld_x), .i_ld_w(i_ld_w), .i_start(i_start), .i_psum_init(i_psum_init),
    .o_x(o_x3), .o_w(o_w3), .o_psum(o_psum3), .o_valid(o_valid3), .i_pe_psum(i_pe_psum3),
    .o_result(o_result3), .o_result_valid(o_result_valid3), .o_busy(o_busy3)
  );

  pe_stream_feeder #(.XW(XW), .WW(WW), .BW1(BW1), .BW2(BW2), .DEPTH(DEPTH), .LAT(1)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready1),
    .i_ld_x(i_ld_x), .i_ld_w(i_ld_w), .i_start(i_start), .i_psum_init(i_psum_init),
    .o_x(o_x1), .o_w(o_w1), .o_psum(o_psum1), .o_valid(o_valid1), .i_pe_psum(i_pe_psum1),
    .o_result(o_result1), .o_result_valid(o_result_valid1), .o_busy(o_busy1)
  );

  // ---------------- behavioural PE chain: sum visible LAT cycles after operand launch
  logic signed [BW2-1:0] pe_now3, pe_now1;
  logic signed [BW2-1:0] pe_d1 = '0;
  logic signed [BW2-1:0] pe_d2 = '0;
  assign pe_now3 = $signed(o_psum3) + $signed(o_x3) * $signed(o_w3);
  assign pe_now1 = $signed(o_psum1) + $signed(o_x1) * $signed(o_w1);
  always @(posedge i_clk) begin
    pe_d1 <= pe_now3;
    pe_d2 <= pe_d1;
  end
  assign i_pe_psum3 = pe_d2;
  assign i_pe_psum1 = pe_now1;

  // ---------------- scoreboard: expected queue mirrors the buffer contents
  logic [XW+WW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_pair(input logic [XW-1:0] x, input logic [WW-1:0] w);
    logic exp_rdy;
    exp_rdy = (exp_q.size() < DEPTH);
    chk("ld_ready3", 32'(o_ld_ready3), 32'(exp_rdy));
    chk("ld_ready1", 32'(o_ld_ready1), 32'(exp_rdy));
    i_ld_valid = 1'b1;
    i_ld_x     = x;
    i_ld_w     = w;
    step();
    i_ld_valid = 1'b0;
    if (exp_rdy) exp_q.push_back({x, w});
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) load_pair(XW'($urandom_range(0, 255)), WW'($urandom_range(0, 255)));
  endtask

  // Issues a start and checks the whole run (or that it is ignored when the buffer is not full).
  task automatic run(input logic [BW1-1:0] init);
    logic           acc;
    logic [XW-1:0]  ex;
    logic [WW-1:0]  ew;
    logic [BW1-1:0] ep;
    logic signed [15:0] prod;
    logic [BW2-1:0] eres;
    acc = (exp_q.size() == DEPTH);
    i_start     = 1'b1;
    i_psum_init = init;
    step();
    i_start     = 1'b0;
    i_psum_init = BW1'($urandom);
    if (!acc) begin
      repeat (3) begin
        chk("ignored_busy3", 32'(o_busy3), 32'(0));
        chk("ignored_busy1", 32'(o_busy1), 32'(0));
        chk("ignored_valid3", 32'(o_valid3), 32'(0));
        step();
      end
      return;
    end
    for (int k = 0; k < DEPTH; k++) begin
      {ex, ew} = exp_q[k];
      ep = (k == 0) ? init : '0;
      chk($sformatf("x3[%0d]", k), 32'(o_x3), 32'(ex));
      chk($sformatf("w3[%0d]", k), 32'(o_w3), 32'(ew));
      chk($sformatf("psum3[%0d]", k), 32'(o_psum3), 32'(ep));
      chk($sformatf("valid3[%0d]", k), 32'(o_valid3), 32'(1));
      chk($sformatf("busy3[%0d]", k), 32'(o_busy3), 32'(1));
      chk($sformatf("ld_ready3[%0d]", k), 32'(o_ld_ready3), 32'(0));
      chk($sformatf("x1[%0d]", k), 32'(o_x1), 32'(ex));
      chk($sformatf("w1[%0d]", k), 32'(o_w1), 32'(ew));
      chk($sformatf("psum1[%0d]", k), 32'(o_psum1), 32'(ep));
      chk($sformatf("valid1[%0d]", k), 32'(o_valid1), 32'(1));
      chk($sformatf("rv3[%0d]", k), 32'(o_result_valid3), 32'(0));
      chk($sformatf("rv1[%0d]", k), 32'(o_result_valid1), 32'(0));
      step();
    end
    // The final PE sum comes from the last pair alone, which enters with a zero partial sum.
    {ex, ew} = exp_q[DEPTH-1];
    prod = $signed(ex) * $signed(ew);
    eres = BW2'(prod);
    // edge E0+DEPTH
    chk("valid3_fall", 32'(o_valid3), 32'(0));
    chk("x3_idle", 32'(o_x3), 32'(0));
    chk("psum3_idle", 32'(o_psum3), 32'(0));
    chk("valid1_fall", 32'(o_valid1), 32'(0));
    chk("rv1_strobe", 32'(o_result_valid1), 32'(1));
    chk("result1", 32'(o_result1), 32'(eres));
    chk("busy1_fall", 32'(o_busy1), 32'(0));
    chk("rv3_early", 32'(o_result_valid3), 32'(0));
    chk("busy3_drain", 32'(o_busy3), 32'(1));
    chk("ld_ready3_drain", 32'(o_ld_ready3), 32'(0));
    step();
    // edge E0+DEPTH+1
    chk("rv1_oneshot", 32'(o_result_valid1), 32'(0));
    chk("ld_ready1_after", 32'(o_ld_ready1), 32'(!REPLAY));
    chk("rv3_early2", 32'(o_result_valid3), 32'(0));
    chk("busy3_drain2", 32'(o_busy3), 32'(1));
    step();
    // edge E0+DEPTH+2 = E0+DEPTH-1+LAT for LAT 3
    chk("rv3_strobe", 32'(o_result_valid3), 32'(1));
    chk("result3", 32'(o_result3), 32'(eres));
    chk("busy3_fall", 32'(o_busy3), 32'(0));
    step();
    chk("rv3_oneshot", 32'(o_result_valid3), 32'(0));
    chk("result3_hold", 32'(o_result3), 32'(eres));
    chk("ld_ready3_after", 32'(o_ld_ready3), 32'(!REPLAY));
    if (!REPLAY) exp_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x3"}, 32'(o_x3), 32'(0));
    chk({tag, "_w3"}, 32'(o_w3), 32'(0));
    chk({tag, "_psum3"}, 32'(o_psum3), 32'(0));
    chk({tag, "_valid3"}, 32'(o_valid3), 32'(0));
    chk({tag, "_result3"}, 32'(o_result3), 32'(0));
    chk({tag, "_rv3"}, 32'(o_result_valid3), 32'(0));
    chk({tag, "_busy3"}, 32'(o_busy3), 32'(0));
    chk({tag, "_ld_ready3"}, 32'(o_ld_ready3), 32'(1));
    chk({tag, "_valid1"}, 32'(o_valid1), 32'(0));
    chk({tag, "_result1"}, 32'(o_result1), 32'(0));
    chk({tag, "_busy1"}, 32'(o_busy1), 32'(0));
    chk({tag, "_ld_ready1"}, 32'(o_ld_ready1), 32'(1));
  endtask

  // ---------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence
  initial begin
    #2;
    chk_all_zero("reset");
    step();
    step();
    i_rst = 1'b0;

    // Basic stream: 1/5 2/6 3/7 4/8, init 10, result 32.
    load_pair(8'd1, 8'd5);
    load_pair(8'd2, 8'd6);
    load_pair(8'd3, 8'd7);
    load_pair(8'd4, 8'd8);
    run(16'd10);

    // Second start without loads: replays when enabled, ignored otherwise.
    run(16'h0077);
    do_reset();

    // Start with three pairs is ignored, also when a same-cycle load fills the buffer.
    load_random(3);
    run(16'h1234);
    i_ld_valid = 1'b1;
    i_ld_x     = 8'hF3;
    i_ld_w     = 8'h7E;
    i_start    = 1'b1;
    step();
    i_ld_valid = 1'b0;
    i_start    = 1'b0;
    exp_q.push_back({8'hF3, 8'h7E});
    chk("same_cycle_busy3", 32'(o_busy3), 32'(0));
    chk("same_cycle_valid3", 32'(o_valid3), 32'(0));
    chk("same_cycle_busy1", 32'(o_busy1), 32'(0));
    run(16'hBEEF);
    do_reset();

    // Backpressure: extra offers while full must not disturb the buffer.
    load_random(4);
    load_pair(8'hAA, 8'h55);
    load_pair(8'h11, 8'h22);
    run(BW1'($urandom));

    // Reset in the middle of a stream.
    do_reset();
    load_random(4);
    i_start     = 1'b1;
    i_psum_init = 16'h5A5A;
    step();
    i_start = 1'b0;
    step();
    step();
    chk("mid_valid3", 32'(o_valid3), 32'(1));
    i_rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step();
    i_rst = 1'b0;
    exp_q.delete();
    repeat (8) begin
      chk("no_rv3_after_rst", 32'(o_result_valid3), 32'(0));
      chk("no_rv1_after_rst", 32'(o_result_valid1), 32'(0));
      step();
    end
    chk("ld_ready3_post_rst", 32'(o_ld_ready3), 32'(1));
    chk("ld_ready1_post_rst", 32'(o_ld_ready1), 32'(1));

    // Random vectors, including negative operands.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      load_random(DEPTH);
      run(BW1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
